// File: rtl/axi_outstanding_limiter.sv
// AXI4 outstanding-burst limiter between the cluster interconnect master port
// (s_*) and the NoC (m_*). Payloads pass combinationally. AW/AR are throttled
// by per-direction outstanding counters. W beats are held back until their AW
// has been accepted. Underflowing responses are reported as sticky error flags.
module axi_outstanding_limiter #(
    parameter int MAX_WR_OUTS = 8,
    parameter int MAX_RD_OUTS = 8
) (
    input  logic         clk,
    input  logic         rst,
    // upstream AW
    input  logic [3:0]   s_awid,
    input  logic [47:0]  s_awaddr,
    input  logic [7:0]   s_awlen,
    input  logic [2:0]   s_awsize,
    input  logic [1:0]   s_awburst,
    input  logic         s_awlock,
    input  logic [3:0]   s_awcache,
    input  logic [2:0]   s_awprot,
    input  logic [3:0]   s_awqos,
    input  logic         s_awvalid,
    output logic         s_awready,
    // upstream W
    input  logic [255:0] s_wdata,
    input  logic [31:0]  s_wstrb,
    input  logic         s_wlast,
    input  logic         s_wvalid,
    output logic         s_wready,
    // upstream B
    output logic [1:0]   s_bresp,
    output logic [3:0]   s_bid,
    output logic         s_bvalid,
    input  logic         s_bready,
    // upstream AR
    input  logic [3:0]   s_arid,
    input  logic [47:0]  s_araddr,
    input  logic [7:0]   s_arlen,
    input  logic [2:0]   s_arsize,
    input  logic [1:0]   s_arburst,
    input  logic         s_arlock,
    input  logic [3:0]   s_arcache,
    input  logic [2:0]   s_arprot,
    input  logic [3:0]   s_arqos,
    input  logic         s_arvalid,
    output logic         s_arready,
    // upstream R
    output logic [255:0] s_rdata,
    output logic [1:0]   s_rresp,
    output logic [3:0]   s_rid,
    output logic         s_rlast,
    output logic         s_rvalid,
    input  logic         s_rready,
    // NoC AW
    output logic [3:0]   m_awid,
    output logic [47:0]  m_awaddr,
    output logic [7:0]   m_awlen,
    output logic [2:0]   m_awsize,
    output logic [1:0]   m_awburst,
    output logic         m_awlock,
    output logic [3:0]   m_awcache,
    output logic [2:0]   m_awprot,
    output logic [3:0]   m_awqos,
    output logic         m_awvalid,
    input  logic         m_awready,
    // NoC W
    output logic [255:0] m_wdata,
    output logic [31:0]  m_wstrb,
    output logic         m_wlast,
    output logic         m_wvalid,
    input  logic         m_wready,
    // NoC B
    input  logic [1:0]   m_bresp,
    input  logic [3:0]   m_bid,
    input  logic         m_bvalid,
    output logic         m_bready,
    // NoC AR
    output logic [3:0]   m_arid,
    output logic [47:0]  m_araddr,
    output logic [7:0]   m_arlen,
    output logic [2:0]   m_arsize,
    output logic [1:0]   m_arburst,
    output logic         m_arlock,
    output logic [3:0]   m_arcache,
    output logic [2:0]   m_arprot,
    output logic [3:0]   m_arqos,
    output logic         m_arvalid,
    input  logic         m_arready,
    // NoC R
    input  logic [255:0] m_rdata,
    input  logic [1:0]   m_rresp,
    input  logic [3:0]   m_rid,
    input  logic         m_rlast,
    input  logic         m_rvalid,
    output logic         m_rready,
    // status
    output logic [3:0]   wr_outstanding,
    output logic [3:0]   rd_outstanding,
    output logic [1:0]   err_underflow,
    input  logic         err_clr
);

    localparam logic [3:0] WR_MAX = 4'(MAX_WR_OUTS);
    localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUTS);

    logic [3:0] wr_cnt, rd_cnt, w_credit;
    logic [3:0] wr_cnt_next, rd_cnt_next, w_credit_next, w_credit_raw;
    logic [1:0] err_set;
    logic       wr_full, rd_full, w_open;
    logic       aw_hs, b_hs, wl_hs, ar_hs, rl_hs;

    // payload pass-through, zero latency
    assign m_awid    = s_awid;
    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;
    assign m_awlock  = s_awlock;
    assign m_awcache = s_awcache;
    assign m_awprot  = s_awprot;
    assign m_awqos   = s_awqos;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = s_wlast;
    assign s_bresp   = m_bresp;
    assign s_bid     = m_bid;
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;
    assign m_arlock  = s_arlock;
    assign m_arcache = s_arcache;
    assign m_arprot  = s_arprot;
    assign m_arqos   = s_arqos;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rid     = m_rid;
    assign s_rlast   = m_rlast;

    // full only rises on our own address handshake, so a held valid is never retracted
    assign wr_full   = (wr_cnt == WR_MAX);
    assign rd_full   = (rd_cnt == RD_MAX);
    assign w_open    = (w_credit != 4'd0);

    assign m_awvalid = s_awvalid & ~wr_full;
    assign s_awready = m_awready & ~wr_full;
    assign m_wvalid  = s_wvalid & w_open;
    assign s_wready  = m_wready & w_open;
    assign s_bvalid  = m_bvalid;
    assign m_bready  = s_bready;
    assign m_arvalid = s_arvalid & ~rd_full;
    assign s_arready = m_arready & ~rd_full;
    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;

    assign aw_hs = m_awvalid & m_awready;
    assign b_hs  = m_bvalid & s_bready;
    assign wl_hs = m_wvalid & m_wready & s_wlast;
    assign ar_hs = m_arvalid & m_arready;
    assign rl_hs = m_rvalid & s_rready & m_rlast;

    assign err_set = {rl_hs & (rd_cnt == 4'd0), b_hs & (wr_cnt == 4'd0)};

    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;

    // next-state of counters; decrements saturate at zero, credit never exceeds wr_cnt
    always_comb begin
        wr_cnt_next = wr_cnt;
        if (aw_hs && !b_hs)
            wr_cnt_next = wr_cnt + 4'd1;
        else if (b_hs && !aw_hs && wr_cnt != 4'd0)
            wr_cnt_next = wr_cnt - 4'd1;

        rd_cnt_next = rd_cnt;
        if (ar_hs && !rl_hs)
            rd_cnt_next = rd_cnt + 4'd1;
        else if (rl_hs && !ar_hs && rd_cnt != 4'd0)
            rd_cnt_next = rd_cnt - 4'd1;

        w_credit_raw = w_credit;
        if (aw_hs && !wl_hs)
            w_credit_raw = w_credit + 4'd1;
        else if (wl_hs && !aw_hs && w_credit != 4'd0)
            w_credit_raw = w_credit - 4'd1;
        w_credit_next = (w_credit_raw > wr_cnt_next) ? wr_cnt_next : w_credit_raw;
    end

    // state registers; a same-cycle error set overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt        <= 4'd0;
            rd_cnt        <= 4'd0;
            w_credit      <= 4'd0;
            err_underflow <= 2'b00;
        end else begin
            wr_cnt        <= wr_cnt_next;
            rd_cnt        <= rd_cnt_next;
            w_credit      <= w_credit_next;
            err_underflow <= (err_underflow & {2{~err_clr}}) | err_set;
        end
    end

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Self-checking bench for axi_outstanding_limiter: table vectors, directed
// corner sequences and a randomized run against a counting reference model.
module tb_axi_outstanding_limiter;

    localparam int MAXW = 8;
    localparam int MAXR = 8;

    logic clk = 1'b0, rst, err_clr;
    logic [3:0] s_awid, m_awid, s_arid, m_arid;
    logic [47:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0] s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0] s_awsize, m_awsize, s_arsize, m_arsize;
    logic [1:0] s_awburst, m_awburst, s_arburst, m_arburst;
    logic s_awlock, m_awlock, s_arlock, m_arlock;
    logic [3:0] s_awcache, m_awcache, s_arcache, m_arcache;
    logic [2:0] s_awprot, m_awprot, s_arprot, m_arprot;
    logic [3:0] s_awqos, m_awqos, s_arqos, m_arqos;
    logic s_awvalid, s_awready, m_awvalid, m_awready;
    logic s_arvalid, s_arready, m_arvalid, m_arready;
    logic [255:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [31:0] s_wstrb, m_wstrb;
    logic s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0] s_bresp, m_bresp, s_rresp, m_rresp;
    logic [3:0] s_bid, m_bid, s_rid, m_rid;
    logic s_bvalid, s_bready, m_bvalid, m_bready;
    logic s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;
    logic [3:0] wr_outstanding, rd_outstanding;
    logic [1:0] err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: plain outstanding counts and W credit
    int mw, mr, mc;
    logic [1:0] merr;

    typedef struct {
        logic [12:0] ctl;  // awv awr | wv wl wrdy | bv brdy | arv arr | rv rl rrdy | clr
        logic [3:0]  ew;
        logic [3:0]  er;
        logic [1:0]  ee;
    } vec_t;
    vec_t tbl[16];

    axi_outstanding_limiter #(.MAX_WR_OUTS(MAXW), .MAX_RD_OUTS(MAXR)) dut (
        .clk(clk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bid(s_bid), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .err_underflow(err_underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic [12:0] c);
        {s_awvalid, m_awready, s_wvalid, s_wlast, m_wready, m_bvalid, s_bready,
         s_arvalid, m_arready, m_rvalid, m_rlast, s_rready, err_clr} = c;
    endtask

    task automatic model_reset();
        mw = 0; mr = 0; mc = 0; merr = 2'b00;
    endtask

    task automatic rand_payload();
        s_awid = 4'($urandom); s_awaddr = {16'($urandom), $urandom}; s_awlen = 8'($urandom);
        s_awsize = 3'($urandom); s_awburst = 2'($urandom); s_awlock = 1'($urandom);
        s_awcache = 4'($urandom); s_awprot = 3'($urandom); s_awqos = 4'($urandom);
        s_arid = 4'($urandom); s_araddr = {16'($urandom), $urandom}; s_arlen = 8'($urandom);
        s_arsize = 3'($urandom); s_arburst = 2'($urandom); s_arlock = 1'($urandom);
        s_arcache = 4'($urandom); s_arprot = 3'($urandom); s_arqos = 4'($urandom);
        for (int k = 0; k < 8; k++) begin
            s_wdata[k*32 +: 32] = $urandom;
            m_rdata[k*32 +: 32] = $urandom;
        end
        s_wstrb = $urandom; m_bresp = 2'($urandom); m_bid = 4'($urandom);
        m_rresp = 2'($urandom); m_rid = 4'($urandom);
    endtask

    // one clock cycle: check all outputs mid-cycle against the model, then advance it
    task automatic step();
        int aw, b, wl, ar, rl;
        logic wfull, rfull, wopen;
        logic [1:0] set;
        rand_payload();
        @(negedge clk);
        wfull = (mw == MAXW);
        rfull = (mr == MAXR);
        wopen = (mc != 0);
        chk("m_awvalid", m_awvalid, s_awvalid && !wfull);
        chk("s_awready", s_awready, m_awready && !wfull);
        chk("m_wvalid", m_wvalid, s_wvalid && wopen);
        chk("s_wready", s_wready, m_wready && wopen);
        chk("s_bvalid", s_bvalid, m_bvalid);
        chk("m_bready", m_bready, s_bready);
        chk("m_arvalid", m_arvalid, s_arvalid && !rfull);
        chk("s_arready", s_arready, m_arready && !rfull);
        chk("s_rvalid", s_rvalid, m_rvalid);
        chk("m_rready", m_rready, s_rready);
        chk("wr_outstanding", wr_outstanding, mw);
        chk("rd_outstanding", rd_outstanding, mr);
        chk("err_underflow", err_underflow, merr);
        chk("aw_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos},
                          {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos});
        chk("ar_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos},
                          {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos});
        chk("w_payload", {m_wdata, m_wstrb, m_wlast}, {s_wdata, s_wstrb, s_wlast});
        chk("b_payload", {s_bresp, s_bid}, {m_bresp, m_bid});
        chk("r_payload", {s_rdata, s_rresp, s_rid, s_rlast}, {m_rdata, m_rresp, m_rid, m_rlast});
        aw = (s_awvalid && !wfull && m_awready) ? 1 : 0;
        b  = (m_bvalid && s_bready) ? 1 : 0;
        wl = (s_wvalid && wopen && m_wready && s_wlast) ? 1 : 0;
        ar = (s_arvalid && !rfull && m_arready) ? 1 : 0;
        rl = (m_rvalid && s_rready && m_rlast) ? 1 : 0;
        @(posedge clk);
        set = {(rl == 1 && mr == 0), (b == 1 && mw == 0)};
        if (err_clr) merr = 2'b00;
        merr = merr | set;
        mw = mw + aw - b;
        if (mw < 0) mw = 0;
        mc = mc + aw - wl;
        if (mc < 0) mc = 0;
        if (mc > mw) mc = mw;
        mr = mr + ar - rl;
        if (mr < 0) mr = 0;
        #1;
    endtask

    initial begin
        tbl[0]  = '{13'b11_000_00_00_000_0, 4'd1, 4'd0, 2'b00}; // AW
        tbl[1]  = '{13'b00_111_00_00_000_0, 4'd1, 4'd0, 2'b00}; // W last consumes credit
        tbl[2]  = '{13'b00_000_11_00_000_0, 4'd0, 4'd0, 2'b00}; // B
        tbl[3]  = '{13'b00_000_11_00_000_0, 4'd0, 4'd0, 2'b01}; // B with nothing outstanding
        tbl[4]  = '{13'b00_000_00_00_000_1, 4'd0, 4'd0, 2'b00}; // clear
        tbl[5]  = '{13'b00_000_00_11_000_0, 4'd0, 4'd1, 2'b00}; // AR
        tbl[6]  = '{13'b00_000_00_00_101_0, 4'd0, 4'd1, 2'b00}; // R non-last
        tbl[7]  = '{13'b00_000_00_00_111_0, 4'd0, 4'd0, 2'b00}; // R last
        tbl[8]  = '{13'b00_000_00_00_111_0, 4'd0, 4'd0, 2'b10}; // R last with nothing outstanding
        tbl[9]  = '{13'b00_000_00_00_111_1, 4'd0, 4'd0, 2'b10}; // set beats clear
        tbl[10] = '{13'b00_000_00_00_000_1, 4'd0, 4'd0, 2'b00}; // clear
        tbl[11] = '{13'b11_000_00_11_000_0, 4'd1, 4'd1, 2'b00}; // AW + AR
        tbl[12] = '{13'b11_000_11_00_000_0, 4'd1, 4'd1, 2'b00}; // AW + B same cycle
        tbl[13] = '{13'b00_000_00_11_111_0, 4'd1, 4'd1, 2'b00}; // AR + R last same cycle
        tbl[14] = '{13'b00_000_11_00_000_0, 4'd0, 4'd1, 2'b00}; // B
        tbl[15] = '{13'b00_000_00_00_111_0, 4'd0, 4'd0, 2'b00}; // R last

        // reset state
        rst = 1'b1;
        set_ctl(13'd0);
        rand_payload();
        model_reset();
        #2;
        chk("rst_wr_outstanding", wr_outstanding, 4'd0);
        chk("rst_rd_outstanding", rd_outstanding, 4'd0);
        chk("rst_err", err_underflow, 2'b00);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}, 5'd0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;
        step();

        // table vectors
        for (int i = 0; i < 16; i++) begin
            set_ctl(tbl[i].ctl);
            step();
            chk($sformatf("tbl%0d_wr", i), wr_outstanding, tbl[i].ew);
            chk($sformatf("tbl%0d_rd", i), rd_outstanding, tbl[i].er);
            chk($sformatf("tbl%0d_err", i), err_underflow, tbl[i].ee);
        end

        // fill to the write limit, 9th AW stalls, one B frees a slot
        set_ctl(13'b11_000_00_00_000_0);
        for (int i = 0; i < 8; i++) step();
        chk("lim_wr8", wr_outstanding, 4'd8);
        #1;
        chk("lim_awready_full", s_awready, 1'b0);
        chk("lim_awvalid_full", m_awvalid, 1'b0);
        set_ctl(13'b11_000_11_00_000_0);
        step();
        chk("lim_wr7_after_b", wr_outstanding, 4'd7);
        set_ctl(13'b11_000_00_00_000_0);
        #1;
        chk("lim_awready_free", s_awready, 1'b1);
        step();
        chk("lim_wr8_again", wr_outstanding, 4'd8);

        // same-cycle AW and B at count 5
        set_ctl(13'b00_000_11_00_000_0);
        for (int i = 0; i < 3; i++) step();
        chk("coinc_wr5", wr_outstanding, 4'd5);
        set_ctl(13'b11_000_11_00_000_0);
        step();
        chk("coinc_wr_stays5", wr_outstanding, 4'd5);
        set_ctl(13'b00_000_11_00_000_0);
        for (int i = 0; i < 5; i++) step();
        chk("coinc_drained", wr_outstanding, 4'd0);

        // W ahead of its AW stalls until the cycle after the AW handshake
        set_ctl(13'b00_111_00_00_000_0);
        #1;
        chk("wfirst_blocked", m_wvalid, 1'b0);
        step();
        set_ctl(13'b11_111_00_00_000_0);
        #1;
        chk("wfirst_blocked_awcycle", m_wvalid, 1'b0);
        step();
        set_ctl(13'b00_111_00_00_000_0);
        #1;
        chk("wfirst_open_next", m_wvalid, 1'b1);
        step();
        #1;
        chk("wfirst_credit_back0", m_wvalid, 1'b0);
        set_ctl(13'b00_000_11_00_000_0);
        step();

        // read burst of 4 beats: count drops only on the last beat
        set_ctl(13'b00_000_00_11_000_0);
        step();
        chk("rburst_rd1", rd_outstanding, 4'd1);
        set_ctl(13'b00_000_00_00_101_0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rburst_beat%0d", i), rd_outstanding, 4'd1);
        end
        set_ctl(13'b00_000_00_00_111_0);
        step();
        chk("rburst_last", rd_outstanding, 4'd0);

        // asynchronous reset mid-transfer, then a stale R last
        set_ctl(13'b11_000_00_00_000_0);
        for (int i = 0; i < 3; i++) step();
        set_ctl(13'b00_000_00_11_000_0);
        for (int i = 0; i < 2; i++) step();
        chk("pre_rst_wr3", wr_outstanding, 4'd3);
        chk("pre_rst_rd2", rd_outstanding, 4'd2);
        set_ctl(13'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_wr", wr_outstanding, 4'd0);
        chk("async_rst_rd", rd_outstanding, 4'd0);
        model_reset();
        #2;
        rst = 1'b0;
        step();
        set_ctl(13'b00_000_00_00_111_0);
        step();
        chk("stale_rlast_err", err_underflow, 2'b10);
        set_ctl(13'b00_000_00_00_000_1);
        step();

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            s_awvalid = ($urandom_range(0, 99) < 60); m_awready = ($urandom_range(0, 99) < 70);
            s_wvalid  = ($urandom_range(0, 99) < 50); s_wlast   = ($urandom_range(0, 99) < 50);
            m_wready  = ($urandom_range(0, 99) < 70);
            m_bvalid  = ($urandom_range(0, 99) < 30); s_bready  = ($urandom_range(0, 99) < 70);
            s_arvalid = ($urandom_range(0, 99) < 50); m_arready = ($urandom_range(0, 99) < 70);
            m_rvalid  = ($urandom_range(0, 99) < 40); m_rlast   = ($urandom_range(0, 99) < 40);
            s_rready  = ($urandom_range(0, 99) < 70);
            err_clr   = ($urandom_range(0, 99) < 5);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
